// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA burst arbiter: FSM state codes, channel
// index width helper and the FIFO words_used/full to occupancy conversion.
package dma_arb_pkg;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    // Widest words_used field the count helper accepts.
    localparam int MAX_W_COUNT = 16;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int W_CH_DEFAULT = ch_width(4);

    // A full FIFO reports words_used = 0, so the full flag supplies the top bit.
    function automatic logic [MAX_W_COUNT:0] fifo_count(
        input logic [MAX_W_COUNT-1:0] words_used,
        input logic                   full,
        input int                     w_count
    );
        if (full) begin
            return (MAX_W_COUNT+1)'(1) << w_count;
        end
        return {1'b0, words_used};
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around. Shared by full-burst and flush selection.
module rr_priority_picker
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int W_IDX  = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [W_IDX-1:0]  ptr,
    output logic              found,
    output logic [W_IDX-1:0]  idx
);

    logic [W_IDX-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = W_IDX'((int'(ptr) + i) % NUM_CH);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dma_burst_arbiter.sv
// Round-robin burst arbiter draining NUM_CH show-ahead FIFOs into a DMA write
// engine. Optional partial-burst flush on idle timeout: define FLUSH_TIMEOUT_EN.
module dma_burst_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int W_DATA    = 32,
    parameter int W_COUNT   = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*W_DATA-1:0]    fifo_rd_data,
    input  logic [NUM_CH*W_COUNT-1:0]   fifo_words_used,
    input  logic [NUM_CH-1:0]           fifo_is_empty,
    input  logic [NUM_CH-1:0]           fifo_is_full,
    output logic [NUM_CH-1:0]           fifo_rd_en,
    output logic [W_DATA-1:0]           dma_data,
    output logic                        dma_valid,
    input  logic                        dma_ready,
    output logic                        dma_sop,
    output logic                        dma_eop,
    output logic [$clog2(NUM_CH)-1:0]   dma_ch,
    output logic [W_COUNT:0]            dma_len
);

    localparam int               W_CH     = ch_width(NUM_CH);
    localparam logic [W_COUNT:0] FULL_LEN = (W_COUNT+1)'(BURST_LEN);

    logic [0:0]        state;
    logic [W_CH-1:0]   ptr;
    logic [W_CH-1:0]   grant;
    logic [W_COUNT:0]  len_q;
    logic [W_COUNT:0]  beat;

    logic [W_COUNT:0]  count [NUM_CH];
    logic [NUM_CH-1:0] eligible;
    logic              full_found;
    logic [W_CH-1:0]   full_idx;
    logic              handshake;
    logic              last_beat;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            count[c]    = (W_COUNT+1)'(fifo_count(
                              MAX_W_COUNT'(fifo_words_used[c*W_COUNT +: W_COUNT]),
                              fifo_is_full[c], W_COUNT));
            eligible[c] = count[c] >= FULL_LEN;
        end
    end

    rr_priority_picker #(
        .NUM_CH (NUM_CH),
        .W_IDX  (W_CH)
    ) u_full_picker (
        .req   (eligible),
        .ptr   (ptr),
        .found (full_found),
        .idx   (full_idx)
    );

`ifdef FLUSH_TIMEOUT_EN
    localparam int W_IDLE = $clog2(TIMEOUT + 1);

    logic [NUM_CH-1:0] nonempty;
    logic              flush_found;
    logic [W_CH-1:0]   flush_idx;
    logic              flush_fire;
    logic [W_IDLE-1:0] idle_cnt;

    assign nonempty = ~fifo_is_empty;

    rr_priority_picker #(
        .NUM_CH (NUM_CH),
        .W_IDX  (W_CH)
    ) u_flush_picker (
        .req   (nonempty),
        .ptr   (ptr),
        .found (flush_found),
        .idx   (flush_idx)
    );

    // Fires on the TIMEOUT-th consecutive idle cycle with data waiting but no full burst.
    assign flush_fire = (state == IDLE) && !full_found && flush_found
                        && (idle_cnt == W_IDLE'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != IDLE || full_found || !flush_found || flush_fire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + W_IDLE'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{fifo_is_empty, 32'(TIMEOUT)};
`endif

    // Reset gates the stream immediately so no beat or pop happens during it.
    assign dma_valid = (state == STREAM) && !rst;
    assign dma_data  = fifo_rd_data[int'(grant)*W_DATA +: W_DATA];
    assign handshake = dma_valid && dma_ready;
    assign last_beat = (beat == len_q - (W_COUNT+1)'(1));
    assign dma_sop   = dma_valid && (beat == '0);
    assign dma_eop   = dma_valid && last_beat;
    assign dma_ch    = grant;
    assign dma_len   = len_q;

    always_comb begin
        fifo_rd_en = '0;
        if (handshake) begin
            fifo_rd_en[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            len_q <= '0;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_found) begin
                        grant <= full_idx;
                        len_q <= FULL_LEN;
                        beat  <= '0;
                        state <= STREAM;
                    end
`ifdef FLUSH_TIMEOUT_EN
                    else if (flush_fire) begin
                        grant <= flush_idx;
                        len_q <= count[flush_idx];
                        beat  <= '0;
                        state <= STREAM;
                    end
`endif
                end
                STREAM: begin
                    if (handshake) begin
                        if (last_beat) begin
                            // The channel just served drops to lowest priority.
                            ptr   <= (grant == W_CH'(NUM_CH - 1)) ? '0 : grant + W_CH'(1);
                            state <= IDLE;
                        end else begin
                            beat <= beat + (W_COUNT+1)'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_arbiter.sv
// Directed self-checking bench for dma_burst_arbiter with a behavioural
// show-ahead FIFO per channel; flush checks depend on FLUSH_TIMEOUT_EN.
module tb_dma_burst_arbiter;

    localparam int NUM_CH    = 4;
    localparam int W_DATA    = 32;
    localparam int W_COUNT   = 8;
    localparam int BURST_LEN = 16;
    localparam int TIMEOUT   = 8;
    localparam int DEPTH     = 512;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_CH*W_DATA-1:0]  fifo_rd_data;
    logic [NUM_CH*W_COUNT-1:0] fifo_words_used;
    logic [NUM_CH-1:0]         fifo_is_empty;
    logic [NUM_CH-1:0]         fifo_is_full;
    logic [NUM_CH-1:0]         fifo_rd_en;
    logic [W_DATA-1:0]         dma_data;
    logic                      dma_valid;
    logic                      dma_ready;
    logic                      dma_sop;
    logic                      dma_eop;
    logic [1:0]                dma_ch;
    logic [W_COUNT:0]          dma_len;

    always #5 clk = ~clk;

    dma_burst_arbiter #(
        .NUM_CH    (NUM_CH),
        .W_DATA    (W_DATA),
        .W_COUNT   (W_COUNT),
        .BURST_LEN (BURST_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_words_used (fifo_words_used),
        .fifo_is_empty   (fifo_is_empty),
        .fifo_is_full    (fifo_is_full),
        .fifo_rd_en      (fifo_rd_en),
        .dma_data        (dma_data),
        .dma_valid       (dma_valid),
        .dma_ready       (dma_ready),
        .dma_sop         (dma_sop),
        .dma_eop         (dma_eop),
        .dma_ch          (dma_ch),
        .dma_len         (dma_len)
    );

    int assert_count = 0;
    int fail_count   = 0;

    logic [W_DATA-1:0] mem [NUM_CH][DEPTH];
    int                fhead [NUM_CH];
    int                fcnt  [NUM_CH];
    int                pops  [NUM_CH] = '{default: 0};
    int                pop_err = 0;
    logic [NUM_CH-1:0] load_req;
    int                load_n    [NUM_CH];
    logic [W_DATA-1:0] load_base [NUM_CH];
    logic              clear_req;

    // Behavioural FIFOs: bulk loads from the stimulus side, pops from the DUT.
    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (clear_req) begin
                fhead[c] <= 0;
                fcnt[c]  <= 0;
            end else begin
                if (fifo_rd_en[c]) begin
                    pops[c] <= pops[c] + 1;
                    if (fcnt[c] == 0) pop_err <= pop_err + 1;
                end
                if (fifo_rd_en[c] && fcnt[c] > 0) fhead[c] <= (fhead[c] + 1) % DEPTH;
                fcnt[c] <= fcnt[c] - ((fifo_rd_en[c] && fcnt[c] > 0) ? 1 : 0)
                                   + (load_req[c] ? load_n[c] : 0);
                if (load_req[c]) begin
                    for (int i = 0; i < load_n[c]; i++) begin
                        mem[c][(fhead[c] + fcnt[c] + i) % DEPTH] <= load_base[c] + W_DATA'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_rd_data[c*W_DATA +: W_DATA]     = mem[c][fhead[c]];
            fifo_words_used[c*W_COUNT +: W_COUNT] = W_COUNT'(fcnt[c]);
            fifo_is_full[c]                      = (fcnt[c] == 256);
            fifo_is_empty[c]                     = (fcnt[c] == 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        load_req  = '0;
        clear_req = 1'b0;
    endtask

    task automatic fill(input int ch, input int n, input logic [W_DATA-1:0] base);
        load_req[ch]  = 1'b1;
        load_n[ch]    = n;
        load_base[ch] = base;
    endtask

    task automatic do_burst(input int ch, input int len, input logic [W_DATA-1:0] base,
                            input bit toggle, input int exp_wait, input string name);
        int         waited;
        int         beat;
        int         k;
        logic [3:0] ready_pat;
        waited    = 0;
        beat      = 0;
        k         = 0;
        ready_pat = 4'b1001;
        dma_ready = 1'b1;
        while (!dma_valid && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, "_start"}, 32'(dma_valid), 32'd1);
        checkOutput({name, "_latency"}, waited, exp_wait);
        if (dma_valid) begin
            while (beat < len && k < 8*len + 8) begin
                dma_ready = toggle ? ready_pat[k % 4] : 1'b1;
                #1;
                checkOutput({name, "_valid"}, 32'(dma_valid), 32'd1);
                checkOutput({name, "_data"},  dma_data, base + W_DATA'(beat));
                checkOutput({name, "_sop"},   32'(dma_sop), (beat == 0) ? 32'd1 : 32'd0);
                checkOutput({name, "_eop"},   32'(dma_eop), (beat == len - 1) ? 32'd1 : 32'd0);
                checkOutput({name, "_ch"},    32'(dma_ch), ch);
                checkOutput({name, "_len"},   32'(dma_len), len);
                checkOutput({name, "_rd_en"}, 32'(fifo_rd_en),
                            dma_ready ? (32'd1 << ch) : 32'd0);
                if (dma_ready) beat++;
                k++;
                @(negedge clk);
            end
            checkOutput({name, "_beats"}, beat, len);
            checkOutput({name, "_gap"}, 32'(dma_valid), 32'd0);
        end
        dma_ready = 1'b1;
    endtask

    task automatic reset_and_clear();
        rst       = 1'b1;
        clear_req = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
    endtask

    // Granted FIFO must never be empty while a beat is offered.
    always @(negedge clk) begin
        if (!rst && dma_valid) begin
            checkOutput("no_underflow", 32'(fifo_is_empty[dma_ch]), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int p2;
        int p3;
        int waited;
        int vcount;

        rst       = 1'b1;
        clear_req = 1'b1;
        load_req  = '0;
        dma_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            load_n[c]    = 0;
            load_base[c] = '0;
        end
        applyStimulus();
        applyStimulus();

        $display("[TB] reset state");
        checkOutput("rst_valid", 32'(dma_valid), 32'd0);
        checkOutput("rst_sop",   32'(dma_sop), 32'd0);
        checkOutput("rst_eop",   32'(dma_eop), 32'd0);
        checkOutput("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("rst_ch",    32'(dma_ch), 32'd0);
        checkOutput("rst_len",   32'(dma_len), 32'd0);
        rst = 1'b0;
        applyStimulus();
        checkOutput("idle_empty_valid", 32'(dma_valid), 32'd0);

        $display("[TB] test 1: single ch2 burst");
        p2 = pops[2];
        fill(2, 16, 32'hA0);
        applyStimulus();
        do_burst(2, 16, 32'hA0, 1'b0, 1, "t1");
        checkOutput("t1_pops", pops[2] - p2, 16);

        $display("[TB] test 2: ch0/ch1 alternation");
        fill(0, 32, 32'h000);
        fill(1, 32, 32'h100);
        applyStimulus();
        do_burst(0, 16, 32'h000, 1'b0, 1, "t2_b0");
        do_burst(1, 16, 32'h100, 1'b0, 1, "t2_b1");
        do_burst(0, 16, 32'h010, 1'b0, 1, "t2_b2");
        do_burst(1, 16, 32'h110, 1'b0, 1, "t2_b3");

        $display("[TB] test 3: backpressure on ch3");
        p3 = pops[3];
        fill(3, 16, 32'h300);
        applyStimulus();
        do_burst(3, 16, 32'h300, 1'b1, 1, "t3");
        checkOutput("t3_pops", pops[3] - p3, 16);

        $display("[TB] test 4: full ch1");
        fill(1, 256, 32'h400);
        applyStimulus();
        do_burst(1, 16, 32'h400, 1'b0, 1, "t4");
        reset_and_clear();

        $display("[TB] test 5: reset mid-burst");
        p0 = pops[0];
        fill(0, 32, 32'h500);
        fill(3, 16, 32'h700);
        applyStimulus();
        waited = 0;
        while (!dma_valid && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("t5_start", 32'(dma_valid), 32'd1);
        checkOutput("t5_first_ch", 32'(dma_ch), 32'd0);
        for (int b = 0; b < 5; b++) begin
            #1;
            checkOutput("t5_pre_data", dma_data, 32'h500 + 32'(b));
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_rd_en_now", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        checkOutput("t5_rst_valid", 32'(dma_valid), 32'd0);
        checkOutput("t5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("t5_rst_sop",   32'(dma_sop), 32'd0);
        checkOutput("t5_rst_eop",   32'(dma_eop), 32'd0);
        checkOutput("t5_rst_ch",    32'(dma_ch), 32'd0);
        checkOutput("t5_rst_len",   32'(dma_len), 32'd0);
        checkOutput("t5_rst_pops",  pops[0] - p0, 5);
        applyStimulus();
        checkOutput("t5_rst_hold_valid", 32'(dma_valid), 32'd0);
        rst = 1'b0;
        do_burst(0, 16, 32'h505, 1'b0, 1, "t5_resume");
        do_burst(3, 16, 32'h700, 1'b0, 1, "t5_ch3");
        checkOutput("t5_total_pops", pops[0] - p0, 21);
        reset_and_clear();

        $display("[TB] test 6: partial ch2 contents");
        p2 = pops[2];
        fill(2, 3, 32'h800);
        applyStimulus();
`ifdef FLUSH_TIMEOUT_EN
        do_burst(2, 3, 32'h800, 1'b0, TIMEOUT, "t6_flush");
        checkOutput("t6_pops", pops[2] - p2, 3);
`else
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (dma_valid) vcount++;
            @(negedge clk);
        end
        checkOutput("t6_no_flush_valid", vcount, 0);
        checkOutput("t6_no_flush_pops", pops[2] - p2, 0);
`endif

        checkOutput("no_pop_underflow", pop_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
